// File: rtl/ps2_device.sv
// PS/2 device endpoint: generates PS2CLK and sends/receives 11-bit frames on open-drain lines.
// Byte accepted on TX_VALID & TX_READY; the host can stall TX by holding the clock low.
module ps2_device #(
  parameter int HALF_CYC = 2000,
  parameter int IDLE_CYC = 2500,
  parameter int SYNC_IGN = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_PERR,
  output logic       RX_FERR,
  output logic       BUSY,
  inout  wire        PS2CLK,
  inout  wire        PS2DATA
);

  localparam int MAXC = (IDLE_CYC > HALF_CYC) ? IDLE_CYC : HALF_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] HALF_MID  = CW'(HALF_CYC / 2);
  localparam logic [CW-1:0] IGN_C     = CW'(SYNC_IGN);
  localparam logic [CW-1:0] IDLE_C    = CW'(IDLE_CYC);

  typedef enum logic [2:0] {
    IDLE, TX_HI, TX_LO, RX_HI, RX_LO, RX_ACK_HI, RX_ACK_LO, RX_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, idle_cnt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic [10:0]   sft, sft_nxt;
  logic [2:0]    clk_sync, dat_sync;
  logic          s_clk, s_dat;
  logic          hold_full, hold_clr;
  logic [7:0]    hold_dat;
  logic          clk_en, dat_en, clk_en_nxt, dat_en_nxt;
  logic          rx_upd, ferr_nxt;
  logic          phase_end, ign_done;

  assign s_clk     = clk_sync[2];
  assign s_dat     = dat_sync[2];
  assign phase_end = (cnt == HALF_LAST);
  assign ign_done  = (cnt >= IGN_C);

  assign PS2CLK   = clk_en ? 1'b0 : 1'bz;
  assign PS2DATA  = dat_en ? 1'b0 : 1'bz;
  assign TX_READY = ~hold_full;
  assign BUSY     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = phase_end ? '0 : cnt + 1'b1;
    bit_nxt   = bit_cnt;
    sft_nxt   = sft;
    hold_clr  = 1'b0;
    rx_upd    = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        bit_nxt = '0;
        if (s_clk && !s_dat) begin
          state_nxt = RX_HI;
        end else if (hold_full && idle_cnt == IDLE_C) begin
          sft_nxt   = {1'b1, ~^hold_dat, hold_dat, 1'b0};
          state_nxt = TX_HI;
        end
      end
      TX_HI: begin
        // host inhibit: abandon the frame, the held byte is resent from the start bit
        if (ign_done && !s_clk) state_nxt = IDLE;
        else if (phase_end)     state_nxt = TX_LO;
      end
      TX_LO: begin
        if (phase_end) begin
          bit_nxt = bit_cnt + 1'b1;
          sft_nxt = {1'b1, sft[10:1]};
          if (bit_cnt == 4'd10) begin
            state_nxt = IDLE;
            hold_clr  = 1'b1;
          end else begin
            state_nxt = TX_HI;
          end
        end
      end
      RX_HI: begin
        if (ign_done && !s_clk) begin
          state_nxt = IDLE;
        end else begin
          if (cnt == HALF_MID) sft_nxt = {s_dat, sft[10:1]};
          if (phase_end) state_nxt = RX_LO;
        end
      end
      RX_LO: begin
        if (phase_end) begin
          bit_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 4'd9) begin
            if (sft[10]) begin
              state_nxt = RX_ACK_HI;
            end else begin
              state_nxt = IDLE;
              ferr_nxt  = 1'b1;
            end
          end else begin
            state_nxt = RX_HI;
          end
        end
      end
      RX_ACK_HI: begin
        if (ign_done && !s_clk) state_nxt = IDLE;
        else if (phase_end)     state_nxt = RX_ACK_LO;
      end
      RX_ACK_LO: if (phase_end) state_nxt = RX_DONE;
      RX_DONE: begin
        rx_upd    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    clk_en_nxt = state_nxt inside {TX_LO, RX_LO, RX_ACK_LO};
    dat_en_nxt = ((state_nxt inside {TX_HI, TX_LO}) && !sft_nxt[0])
               || (state_nxt inside {RX_ACK_HI, RX_ACK_LO});
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      sft       <= '0;
      clk_en    <= 1'b0;
      dat_en    <= 1'b0;
      clk_sync  <= 3'b111;
      dat_sync  <= 3'b111;
      idle_cnt  <= '0;
      hold_full <= 1'b0;
      hold_dat  <= 8'h00;
      RX_DATA   <= 8'h00;
      RX_VALID  <= 1'b0;
      RX_PERR   <= 1'b0;
      RX_FERR   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_nxt;
      sft      <= sft_nxt;
      clk_en   <= clk_en_nxt;
      dat_en   <= dat_en_nxt;
      clk_sync <= {clk_sync[1:0], PS2CLK};
      dat_sync <= {dat_sync[1:0], PS2DATA};
      if (s_clk && s_dat) idle_cnt <= (idle_cnt == IDLE_C) ? idle_cnt : idle_cnt + 1'b1;
      else                idle_cnt <= '0;
      if (hold_clr) begin
        hold_full <= 1'b0;
      end else if (TX_VALID && !hold_full) begin
        hold_full <= 1'b1;
        hold_dat  <= TX_DATA;
      end
      RX_VALID <= rx_upd;
      RX_FERR  <= ferr_nxt;
      if (rx_upd) begin
        RX_DATA <= sft[8:1];
        RX_PERR <= ~^sft[9:1];
      end
    end
  end

endmodule

// File: tb/tb_ps2_device.sv
// Directed bench for ps2_device with an open-drain host model on pulled-up lines.
module tb_ps2_device;
  localparam int HALF = 20;
  localparam int IDLE = 50;
  localparam int IGN  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, rx_perr, rx_ferr, busy;
  logic [7:0] rx_data;
  logic       host_clk_lo = 1'b0;
  logic       host_dat_lo = 1'b0;
  wire        ps2clk, ps2data;

  pullup (ps2clk);
  pullup (ps2data);
  assign ps2clk  = host_clk_lo ? 1'b0 : 1'bz;
  assign ps2data = host_dat_lo ? 1'b0 : 1'bz;

  ps2_device #(.HALF_CYC(HALF), .IDLE_CYC(IDLE), .SYNC_IGN(IGN)) dut (
    .CLK(clk), .RST_N(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_PERR(rx_perr), .RX_FERR(rx_ferr),
    .BUSY(busy), .PS2CLK(ps2clk), .PS2DATA(ps2data)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int vld_cnt = 0;
  int ferr_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) vld_cnt++;
    if (rx_ferr)  ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_falls(input int n, output bit ok);
    logic prev;
    int   got;
    got  = 0;
    prev = ps2clk;
    for (int i = 0; i < 3000 && got < n; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && ps2clk === 1'b0) got++;
      prev = ps2clk;
    end
    ok = (got == n);
  endtask

  task automatic capture_frame(output logic [10:0] bits, output int gap, output int lo0,
                               output int lo_last, output bit ok);
    logic prev;
    int   got, lo;
    bits = '0; gap = 0; lo0 = 0; lo_last = 0; got = 0; lo = 0;
    prev = ps2clk;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && ps2clk === 1'b0) begin
        bits = {ps2data, bits[10:1]};
        got++;
        lo = 0;
      end else if (got == 0) begin
        gap++;
      end
      if (ps2clk === 1'b0) begin
        lo++;
      end else if (prev === 1'b0) begin
        if (got == 1) lo0 = lo;
        lo_last = lo;
      end
      prev = ps2clk;
      if (got == 11 && ps2clk === 1'b1) break;
    end
    ok = (got == 11) && (ps2clk === 1'b1);
  endtask

  // Host request: inhibit, start bit, then d0..d7, parity, stop changed while the clock is low.
  task automatic host_send(input logic [7:0] d, input logic par, input logic stop,
                           output int nfalls, output logic ack);
    logic [9:0] s;
    logic       prev;
    int         since;
    s = {stop, par, d};
    nfalls = 0; ack = 1'b1; since = 0;
    host_clk_lo = 1'b1;
    repeat (30) @(negedge clk);
    host_dat_lo = 1'b1;
    repeat (2) @(negedge clk);
    host_clk_lo = 1'b0;
    repeat (7) @(negedge clk);
    host_dat_lo = ~s[0];
    prev = ps2clk;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && ps2clk === 1'b0) begin
        nfalls++;
        since = 0;
        if (nfalls <= 9) begin
          s = s >> 1;
          host_dat_lo = ~s[0];
        end else if (nfalls == 10) begin
          host_dat_lo = 1'b0;
        end else begin
          ack = ps2data;
        end
      end else begin
        since++;
      end
      prev = ps2clk;
      if (nfalls == 11 && ps2clk === 1'b1) break;
      if (nfalls >= 10 && since > 4 * HALF) break;
    end
    host_dat_lo = 1'b0;
  endtask

  initial begin
    logic [10:0] bits;
    int   gap, lo0, lo_last, nf, v0, f0, rel;
    logic ack;
    bit   ok;

    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_perr", rx_perr, 0);
    check("rst_rx_ferr", rx_ferr, 0);
    check("rst_busy", busy, 0);
    check("rst_ps2clk", ps2clk, 1);
    check("rst_ps2data", ps2data, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // device-to-host byte 1C
    load_byte(8'h1C);
    check("tx_ready_drop", tx_ready, 0);
    capture_frame(bits, gap, lo0, lo_last, ok);
    check("tx1c_complete", ok, 1);
    check("tx1c_bits", bits, 11'h438);
    check("tx1c_lo_first", lo0, HALF);
    check("tx1c_lo_stop", lo_last, HALF);
    check("tx1c_ready_back", tx_ready, 1);
    check("tx1c_busy_end", busy, 0);

    // host-to-device ED, good parity
    v0 = vld_cnt; f0 = ferr_cnt;
    host_send(8'hED, 1'b1, 1'b1, nf, ack);
    repeat (5) @(negedge clk);
    check("rx_ed_falls", nf, 11);
    check("rx_ed_ack", ack, 0);
    check("rx_ed_valid_pulse", vld_cnt - v0, 1);
    check("rx_ed_data", rx_data, 8'hED);
    check("rx_ed_perr", rx_perr, 0);
    check("rx_ed_no_ferr", ferr_cnt - f0, 0);

    // bad parity is still ACKed
    v0 = vld_cnt;
    host_send(8'hED, 1'b0, 1'b1, nf, ack);
    repeat (5) @(negedge clk);
    check("rx_par_falls", nf, 11);
    check("rx_par_ack", ack, 0);
    check("rx_par_valid_pulse", vld_cnt - v0, 1);
    check("rx_par_perr", rx_perr, 1);

    // stop bit 0: no ACK, framing error pulse
    v0 = vld_cnt; f0 = ferr_cnt;
    host_send(8'hED, 1'b1, 1'b0, nf, ack);
    check("rx_ferr_falls", nf, 10);
    check("rx_ferr_data_released", ps2data, 1);
    check("rx_ferr_pulse", ferr_cnt - f0, 1);
    check("rx_ferr_no_valid", vld_cnt - v0, 0);

    // inhibit after d3 of F0, then full resend
    repeat (10) @(negedge clk);
    load_byte(8'hF0);
    wait_falls(5, ok);
    check("inh_five_falls", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (ps2clk === 1'b1);
    end
    check("inh_clock_rose", ok, 1);
    host_clk_lo = 1'b1;
    rel = 0;
    while (busy && rel < 40) begin
      @(negedge clk);
      rel++;
    end
    check("inh_release_fast", (rel <= IGN + 4), 1);
    check("inh_data_released", ps2data, 1);
    check("inh_tx_ready_held", tx_ready, 0);
    repeat (40) @(negedge clk);
    host_clk_lo = 1'b0;
    capture_frame(bits, gap, lo0, lo_last, ok);
    check("resend_complete", ok, 1);
    check("resend_bits", bits, 11'h7E0);
    check("resend_idle_gap", (gap >= IDLE), 1);
    check("resend_ready_back", tx_ready, 1);

    // host request wins over pending TX byte
    host_clk_lo = 1'b1;
    repeat (3) @(negedge clk);
    load_byte(8'h5A);
    check("pend_tx_ready", tx_ready, 0);
    v0 = vld_cnt;
    host_send(8'h3C, 1'b1, 1'b1, nf, ack);
    repeat (3) @(negedge clk);
    check("pend_rx_ack", ack, 0);
    check("pend_rx_valid", vld_cnt - v0, 1);
    check("pend_rx_data", rx_data, 8'h3C);
    check("pend_tx_still_held", tx_ready, 0);
    capture_frame(bits, gap, lo0, lo_last, ok);
    check("pend_tx_complete", ok, 1);
    check("pend_tx_bits", bits, 11'h6B4);

    // reset mid-frame releases lines at once
    load_byte(8'hAA);
    wait_falls(2, ok);
    check("mid_two_falls", ok, 1);
    check("mid_data_driven", ps2data, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ps2clk", ps2clk, 1);
    check("mid_rst_ps2data", ps2data, 1);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
